// File: rtl/fcs_check_par.sv
// fcs_check_par: parallel-beat Ethernet FCS (CRC-32) checker reporting pass/fail, frame length and runt.
// Optional macro FCS_STATS_EN adds saturating GOOD_CNT / BAD_CNT frame counters.
module fcs_check_par #(
    parameter int DATA_W  = 8,
    parameter int MIN_LEN = 64,
    parameter int LEN_W   = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      DATA_VALID,
    input  logic                      SOF,
    input  logic                      EOF,
    input  logic [$clog2(DATA_W/8):0] EOF_BYTES,
    input  logic [DATA_W-1:0]         DATA_IN,
    output logic                      FCS_VALID,
    output logic                      FCS_ERROR,
    output logic                      RUNT,
    output logic [LEN_W-1:0]          FRAME_LEN,
    output logic                      ABORT
`ifdef FCS_STATS_EN
    ,
    output logic [15:0]               GOOD_CNT,
    output logic [15:0]               BAD_CNT
`endif
);
    localparam int unsigned      NB      = DATA_W / 8;
    localparam int               EB_W    = $clog2(DATA_W / 8) + 1;
    localparam logic [31:0]      POLY    = 32'h04C11DB7;
    localparam logic [31:0]      RESIDUE = 32'hC704DD7B;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W:0]   LEN_MIN = (LEN_W + 1)'(MIN_LEN);
    localparam logic [LEN_W:0]   LEN_FCS = (LEN_W + 1)'(4);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t           state, state_nxt;
    logic [31:0]      crc_q, crc_base, crc_nxt;
    logic [LEN_W-1:0] cnt_q, cnt_base, cnt_nxt;
    logic [LEN_W:0]   sum;
    logic [EB_W-1:0]  nbytes;
    logic             start, take, finish, abort_nxt;

    // Shift-left CRC-32, lanes in wire order, each byte LSB first; lanes >= n are skipped.
    function automatic logic [31:0] crc_bytes(input logic [31:0] c, input logic [DATA_W-1:0] d,
                                              input int unsigned n);
        logic [31:0] r;
        logic [7:0]  b;
        logic        fb;
        r = c;
        for (int unsigned l = 0; l < NB; l++) begin
            if (l < n) begin
                b = d[DATA_W-1-8*l -: 8];
                for (int unsigned i = 0; i < 8; i++) begin
                    fb = r[31] ^ b[i];
                    r  = {r[30:0], 1'b0} ^ (fb ? POLY : '0);
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (take) state_nxt = EOF ? IDLE : FRAME;
    end

    // A SOF beat always opens a fresh frame, so it also serves as the restart on abort.
    always_comb begin
        start     = DATA_VALID & SOF;
        take      = DATA_VALID & (SOF | (state == FRAME));
        finish    = take & EOF;
        abort_nxt = start & (state == FRAME);
        if (EOF && (EOF_BYTES != '0) && (EOF_BYTES <= EB_W'(NB))) nbytes = EOF_BYTES;
        else                                                    nbytes = EB_W'(NB);
        crc_base = start ? '1 : crc_q;
        cnt_base = start ? '0 : cnt_q;
        crc_nxt  = crc_bytes(crc_base, DATA_IN, 32'(nbytes));
        sum      = {1'b0, cnt_base} + (LEN_W + 1)'(nbytes);
        cnt_nxt  = sum[LEN_W] ? LEN_MAX : sum[LEN_W-1:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            crc_q     <= '1;
            cnt_q     <= '0;
            FCS_VALID <= 1'b0;
            FCS_ERROR <= 1'b0;
            RUNT      <= 1'b0;
            FRAME_LEN <= '0;
            ABORT     <= 1'b0;
        end else begin
            FCS_VALID <= finish;
            ABORT     <= abort_nxt;
            if (take) begin
                crc_q <= crc_nxt;
                cnt_q <= cnt_nxt;
            end
            if (finish) begin
                FCS_ERROR <= (crc_nxt != RESIDUE) || ({1'b0, cnt_nxt} < LEN_FCS);
                RUNT      <= {1'b0, cnt_nxt} < LEN_MIN;
                FRAME_LEN <= cnt_nxt;
            end
        end
    end

`ifdef FCS_STATS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            GOOD_CNT <= '0;
            BAD_CNT  <= '0;
        end else if (FCS_VALID) begin
            if (FCS_ERROR || RUNT) begin
                if (BAD_CNT != '1) BAD_CNT <= BAD_CNT + 16'd1;
            end else if (GOOD_CNT != '1) begin
                GOOD_CNT <= GOOD_CNT + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fcs_check_par.sv
// Scoreboard bench for fcs_check_par at DATA_W=8 and DATA_W=32 against a table-free software CRC-32 model.
// Stats counters are checked when FCS_STATS_EN is defined.
module tb_fcs_check_par;
    typedef byte unsigned byte_q_t[$];
    typedef struct {
        logic err;
        logic runt;
        int   len;
        int   cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    logic        v8, sof8, eof8, v32, sof32, eof32;
    logic [0:0]  eb8;
    logic [2:0]  eb32;
    logic [7:0]  d8;
    logic [31:0] d32;
    logic        fv8, fe8, rn8, ab8, fv32, fe32, rn32, ab32;
    logic [15:0] fl8, fl32;
`ifdef FCS_STATS_EN
    logic [15:0] gc8, bc8, gc32, bc32;
`endif

    exp_t q8[$], q32[$];
    int   a8[$], a32[$];
    bit   open_f[2];
    int   exp_good[2], exp_bad[2];
    int   n_chk = 0, n_pass = 0;

    byte unsigned known_a[64] = '{
        8'h00, 8'h10, 8'hA4, 8'h7B, 8'hEA, 8'h80, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h90, 8'h08, 8'h00, 8'h45, 8'h00,
        8'h00, 8'h2E, 8'hB3, 8'hFE, 8'h00, 8'h00, 8'h80, 8'h11, 8'h05, 8'h40, 8'hC0, 8'hA8, 8'h00, 8'h2C, 8'hC0, 8'hA8,
        8'h00, 8'h04, 8'h04, 8'h00, 8'h04, 8'h00, 8'h00, 8'h1A, 8'h2D, 8'hE8, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
        8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'hE6, 8'hC5, 8'h3D, 8'hB2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fcs_check_par #(.DATA_W(8), .MIN_LEN(64), .LEN_W(16)) u8 (
        .CLK(clk), .RST(rst_n), .DATA_VALID(v8), .SOF(sof8), .EOF(eof8), .EOF_BYTES(eb8), .DATA_IN(d8),
        .FCS_VALID(fv8), .FCS_ERROR(fe8), .RUNT(rn8), .FRAME_LEN(fl8), .ABORT(ab8)
`ifdef FCS_STATS_EN
        , .GOOD_CNT(gc8), .BAD_CNT(bc8)
`endif
    );

    fcs_check_par #(.DATA_W(32), .MIN_LEN(64), .LEN_W(16)) u32 (
        .CLK(clk), .RST(rst_n), .DATA_VALID(v32), .SOF(sof32), .EOF(eof32), .EOF_BYTES(eb32), .DATA_IN(d32),
        .FCS_VALID(fv32), .FCS_ERROR(fe32), .RUNT(rn32), .FRAME_LEN(fl32), .ABORT(ab32)
`ifdef FCS_STATS_EN
        , .GOOD_CNT(gc32), .BAD_CNT(bc32)
`endif
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Standard reflected software CRC-32 (init all-ones, final inversion).
    function automatic logic [31:0] crc32_ref(input byte_q_t q, input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c ^= {24'h0, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byte_q_t add_fcs(input byte_q_t q);
        logic [31:0] c;
        byte_q_t r;
        r = q;
        c = crc32_ref(q, q.size());
        for (int k = 0; k < 4; k++) r.push_back(c[8*k +: 8]);
        return r;
    endfunction

    // A frame is good when its last four bytes are the little-endian CRC-32 of the bytes before them.
    function automatic exp_t model(input byte_q_t fr, input int at);
        exp_t        e;
        logic [31:0] c;
        bit          good;
        int          n;
        n    = fr.size();
        good = (n >= 4);
        if (good) begin
            c = crc32_ref(fr, n - 4);
            for (int k = 0; k < 4; k++) if (fr[n-4+k] != c[8*k +: 8]) good = 0;
        end
        e.err  = !good;
        e.runt = (n < 64);
        e.len  = (n > 65535) ? 65535 : n;
        e.cyc  = at;
        return e;
    endfunction

    function automatic byte_q_t rand_frame(input int len, input bit good);
        byte_q_t r;
        int      m;
        m = (good && len >= 4) ? len - 4 : len;
        for (int i = 0; i < m; i++) r.push_back(8'($urandom));
        if (good && len >= 4) r = add_fcs(r);
        return r;
    endfunction

    function automatic byte_q_t known(input int n);
        byte_q_t r;
        for (int i = 0; i < n; i++) r.push_back(known_a[i]);
        return r;
    endfunction

    task automatic drive(input int inst, input logic v, input logic s, input logic e,
                         input logic [2:0] eb, input logic [31:0] w);
        if (inst == 0) begin
            v8 = v; sof8 = s; eof8 = e; eb8 = eb[0]; d8 = w[31:24];
        end else begin
            v32 = v; sof32 = s; eof32 = e; eb32 = eb; d32 = w;
        end
    endtask

    task automatic drive_idle(input int inst);
        drive(inst, 1'b0, 1'($urandom), 1'($urandom), 3'($urandom), $urandom);
    endtask

    task automatic idle_all(input int n);
        repeat (n) begin
            drive_idle(0);
            drive_idle(1);
            @(posedge clk); #1;
        end
    endtask

    task automatic push_exp(input int inst, input exp_t e);
        if (inst == 0) q8.push_back(e);
        else           q32.push_back(e);
        if (e.err || e.runt) begin
            if (exp_bad[inst] < 65535) exp_bad[inst]++;
        end else if (exp_good[inst] < 65535) begin
            exp_good[inst]++;
        end
    endtask

    // Sends fr as beats; gaps (valid low, junk on other inputs) go between beats. with_eof=0 leaves it open.
    task automatic send(input int inst, input byte_q_t fr, input int gap_max, input bit with_eof);
        int          nb, len, rem, g, sel;
        logic [31:0] w;
        logic [2:0]  eb;
        bit          last, s, e;
        nb  = (inst == 0) ? 1 : 4;
        len = fr.size();
        for (int p = 0; p < len; p += nb) begin
            if (p > 0) begin
                g = $urandom_range(gap_max, 0);
                repeat (g) begin
                    drive_idle(inst);
                    @(posedge clk); #1;
                end
            end
            w = $urandom;
            for (int l = 0; l < nb; l++) if (p + l < len) w[31-8*l -: 8] = fr[p+l];
            rem  = len - p;
            last = (rem <= nb);
            eb   = 3'(last ? rem : nb);
            if (rem >= nb && $urandom_range(1, 0) == 1) begin
                sel = $urandom_range(3, 0);
                eb  = (inst == 0 || sel == 0) ? 3'd0 : 3'(sel + 4);
            end
            s = (p == 0);
            e = last && with_eof;
            if (s && open_f[inst]) begin
                if (inst == 0) a8.push_back(cyc + 1);
                else           a32.push_back(cyc + 1);
            end
            if (s) open_f[inst] = 1;
            if (e) push_exp(inst, model(fr, cyc + 1));
            drive(inst, 1'b1, s, e, eb, w);
            @(posedge clk); #1;
        end
        if (with_eof) open_f[inst] = 0;
        drive_idle(inst);
    endtask

    task automatic mon(input int inst, input logic fv, input logic fe, input logic rn,
                       input logic [15:0] fl, input logic ab);
        exp_t e;
        int   ac;
        if (fv) begin
            if ((inst == 0) ? (q8.size() == 0) : (q32.size() == 0)) begin
                n_chk++;
                $display("FAIL valid_unexpected%0d: got FCS_VALID at cycle %0d, expected none", inst, cyc);
            end else begin
                e = (inst == 0) ? q8.pop_front() : q32.pop_front();
                check($sformatf("latency%0d", inst), cyc, e.cyc);
                check($sformatf("fcs_error%0d@%0d", inst, cyc), fe, e.err);
                check($sformatf("runt%0d@%0d", inst, cyc), rn, e.runt);
                check($sformatf("frame_len%0d@%0d", inst, cyc), fl, e.len);
            end
        end
        if (ab) begin
            if ((inst == 0) ? (a8.size() == 0) : (a32.size() == 0)) begin
                n_chk++;
                $display("FAIL abort_unexpected%0d: got ABORT at cycle %0d, expected none", inst, cyc);
            end else begin
                ac = (inst == 0) ? a8.pop_front() : a32.pop_front();
                check($sformatf("abort_cycle%0d", inst), cyc, ac);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, fv8, fe8, rn8, fl8, ab8);
        mon(1, fv32, fe32, rn32, fl32, ab32);
    end

    task automatic check_zero(input string tag);
        check({tag, "_valid8"}, fv8, 0);  check({tag, "_err8"}, fe8, 0);  check({tag, "_runt8"}, rn8, 0);
        check({tag, "_len8"}, fl8, 0);    check({tag, "_abort8"}, ab8, 0);
        check({tag, "_valid32"}, fv32, 0); check({tag, "_err32"}, fe32, 0); check({tag, "_runt32"}, rn32, 0);
        check({tag, "_len32"}, fl32, 0);   check({tag, "_abort32"}, ab32, 0);
`ifdef FCS_STATS_EN
        check({tag, "_good8"}, gc8, 0);  check({tag, "_bad8"}, bc8, 0);
        check({tag, "_good32"}, gc32, 0); check({tag, "_bad32"}, bc32, 0);
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q8.size() == 0 && q32.size() == 0 && a8.size() == 0 && a32.size() == 0) break;
            @(posedge clk); #1;
        end
        idle_all(3);
    endtask

    task automatic eof_without_sof(input int inst);
        drive(inst, 1'b1, 1'b0, 1'b1, 3'd1, $urandom);
        @(posedge clk); #1;
        drive_idle(inst);
    endtask

    initial begin
        byte_q_t f, g;
        rst_n = 1'b0;
        drive_idle(0);
        drive_idle(1);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle_all(2);

        // Known frame (good), then FCS replaced by FF FF FF FF, on the byte-wide instance.
        send(0, known(64), 0, 1);
        idle_all(2);
        f = known(60);
        repeat (4) f.push_back(8'hFF);
        send(0, f, 0, 1);
        idle_all(2);

        // Word-wide: known frame, then a 61-byte runt with a correct FCS.
        send(1, known(64), 0, 1);
        send(1, add_fcs(known(57)), 0, 1);
        idle_all(2);

        // Gapped frame followed by a back-to-back frame on both widths.
        for (int inst = 0; inst < 2; inst++) begin
            send(inst, rand_frame($urandom_range(120, 40), 1), 5, 1);
            send(inst, rand_frame($urandom_range(120, 40), 1), 0, 1);
            idle_all(2);
        end

        // Abort: SOF at byte 20 of an open frame, then a full good frame.
        for (int inst = 0; inst < 2; inst++) begin
            send(inst, rand_frame(20, 0), 1, 0);
            send(inst, known(64), 0, 1);
            idle_all(2);
        end

        // Stray EOF, tiny frames, and the 4-byte all-zero frame whose FCS is valid.
        for (int inst = 0; inst < 2; inst++) begin
            eof_without_sof(inst);
            idle_all(1);
            for (int n = 1; n <= 4; n++) begin
                send(inst, rand_frame(n, 1), 0, 1);
                idle_all(1);
            end
            f = {};
            send(inst, add_fcs(f), 0, 1);
            idle_all(1);
            send(inst, rand_frame(63, 1), 0, 1);
            send(inst, rand_frame(64, 1), 0, 1);
            idle_all(1);
        end

        for (int i = 0; i < 30; i++) begin
            for (int inst = 0; inst < 2; inst++) begin
                if ($urandom_range(7, 0) == 0) send(inst, rand_frame($urandom_range(30, 2), 0), 2, 0);
                send(inst, rand_frame($urandom_range(130, 1), 1'($urandom)), $urandom_range(3, 0), 1);
                if ($urandom_range(3, 0) == 0) idle_all($urandom_range(3, 1));
            end
        end
        drain();

`ifndef FCS_STATS_EN
        // Byte counter saturates for an oversized frame.
        send(1, rand_frame(65540, 1), 0, 1);
        drain();
`else
        check("good_cnt8", gc8, exp_good[0]);
        check("bad_cnt8", bc8, exp_bad[0]);
        check("good_cnt32", gc32, exp_good[1]);
        check("bad_cnt32", bc32, exp_bad[1]);
        for (int i = 0; i < 65537; i++) begin
            g = rand_frame(1, 0);
            send(1, g, 0, 1);
        end
        drain();
        check("bad_cnt32_sat", bc32, exp_bad[1]);
        check("bad_cnt32_max", bc32, 16'hFFFF);
        check("good_cnt32_hold", gc32, exp_good[1]);
`endif

        // Reset at byte 30 of open frames: lost, no strobe, outputs cleared.
        send(0, rand_frame(30, 1), 0, 0);
        send(1, rand_frame(30, 1), 0, 0);
        rst_n = 1'b0;
        #2;
        check_zero("midreset");
        @(posedge clk); #1;
        rst_n     = 1'b1;
        open_f[0] = 0;
        open_f[1] = 0;
        exp_good  = '{0, 0};
        exp_bad   = '{0, 0};
        idle_all(5);
        send(0, known(64), 2, 1);
        send(1, known(64), 2, 1);
        drain();

        check("pending_results8", q8.size(), 0);
        check("pending_results32", q32.size(), 0);
        check("pending_aborts8", a8.size(), 0);
        check("pending_aborts32", a32.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
